// File: rtl/cpu_core.sv
// Multicycle 8-bit-register core with 16-bit instructions and one request/acknowledge
// memory port, shared by instruction fetch and byte-wide LD/ST.
module cpu_core #(
  parameter int PC_W     = 7,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic            mem_we,
  output logic [PC_W-1:0] mem_addr,
  output logic [1:0]      mem_be,
  output logic [15:0]     mem_wdata,
  input  logic [15:0]     mem_rdata,
  input  logic            mem_ack,
  output logic            halted,
  output logic            retire,
  output logic [PC_W-1:0] pc
);

  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, MEM = 2'd2, HALT_ST = 2'd3} state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          state_r, state_nxt_s;
  logic [PC_W-1:0] pc_r;
  logic [15:0]     ir_r;
  logic [7:0]      regs_r [16];

  logic [3:0]      op_s, rd_s, rs1_s, rs2_s;
  logic [7:0]      imm_s, rs1_val_s, rs2_val_s, rd_val_s, alu_s;
  logic [PC_W-1:0] ea_s, pc_inc_s, target_s;
  logic            byte_sel_s, req_s, done_s;

  assign op_s       = ir_r[15:12];
  assign rd_s       = ir_r[11:8];
  assign rs1_s      = ir_r[7:4];
  assign rs2_s      = ir_r[3:0];
  assign imm_s      = ir_r[7:0];
  assign rs1_val_s  = regs_r[rs1_s];
  assign rs2_val_s  = regs_r[rs2_s];
  assign rd_val_s   = regs_r[rd_s];
  // Data word address is the register value without its byte-select bit.
  assign ea_s       = PC_W'(rs1_val_s[7:1]);
  assign byte_sel_s = rs1_val_s[0];
  assign target_s   = PC_W'(imm_s);
  assign pc_inc_s   = pc_r + PC_W'(1);
  // The request is masked while reset is asserted so nothing is issued during reset.
  assign req_s      = rst_n && ((state_r == FETCH) || (state_r == MEM));
  assign done_s     = req_s && mem_ack;
  assign pc         = pc_r;
  assign halted     = (state_r == HALT_ST);

  // ALU result for the register-register ops.
  always_comb begin
    alu_s = 8'h00;
    case (op_s)
      OP_ADD:  alu_s = rs1_val_s + rs2_val_s;
      OP_SUB:  alu_s = rs1_val_s - rs2_val_s;
      OP_AND:  alu_s = rs1_val_s & rs2_val_s;
      OP_OR:   alu_s = rs1_val_s | rs2_val_s;
      OP_XOR:  alu_s = rs1_val_s ^ rs2_val_s;
      default: alu_s = 8'h00;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= FETCH;
    else        state_r <= state_nxt_s;
  end

  // Next state and memory/retire outputs.
  always_comb begin
    state_nxt_s = state_r;
    mem_req     = req_s;
    mem_we      = 1'b0;
    mem_addr    = pc_r;
    mem_be      = 2'b00;
    mem_wdata   = 16'h0000;
    retire      = 1'b0;
    case (state_r)
      FETCH: begin
        mem_be = 2'b11;
        if (done_s) state_nxt_s = EXEC;
        else        state_nxt_s = FETCH;
      end
      EXEC: begin
        case (op_s)
          OP_LD, OP_ST: state_nxt_s = MEM;
          OP_HALT: begin
            state_nxt_s = HALT_ST;
            retire      = rst_n;
          end
          default: begin
            state_nxt_s = FETCH;
            retire      = rst_n;
          end
        endcase
      end
      MEM: begin
        mem_addr = ea_s;
        if (op_s == OP_ST) begin
          mem_we    = req_s;
          mem_be    = byte_sel_s ? 2'b10 : 2'b01;
          mem_wdata = {rs2_val_s, rs2_val_s};
        end else begin
          mem_be    = 2'b11;
        end
        if (done_s) begin
          state_nxt_s = FETCH;
          retire      = 1'b1;
        end else begin
          state_nxt_s = MEM;
        end
      end
      HALT_ST: state_nxt_s = HALT_ST;
      default: state_nxt_s = FETCH;
    endcase
  end

  // Program counter, instruction register and register file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r <= PC_W'(RESET_PC);
      ir_r <= 16'h0000;
      for (int i = 0; i < 16; i++) regs_r[i] <= 8'h00;
    end else begin
      case (state_r)
        FETCH: begin
          if (done_s) begin
            ir_r <= mem_rdata;
            pc_r <= pc_inc_s;
          end
        end
        EXEC: begin
          case (op_s)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: regs_r[rd_s] <= alu_s;
            OP_LDI: regs_r[rd_s] <= imm_s;
            OP_JMP: pc_r <= target_s;
            OP_BZ: begin
              if (rd_val_s == 8'h00) pc_r <= target_s;
            end
            default: begin
            end
          endcase
        end
        MEM: begin
          if (done_s && (op_s == OP_LD))
            regs_r[rd_s] <= byte_sel_s ? mem_rdata[15:8] : mem_rdata[7:0];
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: memory responder with scripted wait states and an
// instruction-level reference model for randomized programs.
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req, mem_we, mem_ack, halted, retire;
  logic [6:0]  mem_addr, pc;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [128];
  logic [15:0] ref_mem [128];
  int          ref_regs [16];
  int          wait_seq [256];
  int          req_idx = 0;
  int          wcnt = 0;
  bit          pending = 1'b0;
  bit          stray_ack = 1'b0;
  logic [6:0]  cap_addr;
  logic        cap_we;
  logic [1:0]  cap_be;
  logic [15:0] cap_wdata;
  logic [6:0]  log_addr [$];
  logic        log_we [$];
  logic [1:0]  log_be [$];
  logic [15:0] log_wdata [$];
  int          ret_cnt = 0;
  int          cyc_cnt = 0;
  int          ret_q [$];

  cpu_core #(.PC_W(7), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halted(halted), .retire(retire), .pc(pc)
  );

  always #5 clk = ~clk;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
  end

  // Memory responder: acts 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (mem_req === 1'b1) begin
      if (!pending) begin
        pending   = 1'b1;
        wcnt      = wait_seq[req_idx % 256];
        cap_addr  = mem_addr;
        cap_we    = mem_we;
        cap_be    = mem_be;
        cap_wdata = mem_wdata;
      end else begin
        total++;
        if (mem_addr !== cap_addr || mem_we !== cap_we || mem_be !== cap_be || mem_wdata !== cap_wdata) begin
          bad++;
          $display("FAIL req_stable: got addr=%h we=%b be=%b wdata=%h, required addr=%h we=%b be=%b wdata=%h",
                   mem_addr, mem_we, mem_be, mem_wdata, cap_addr, cap_we, cap_be, cap_wdata);
        end
      end
      if (wcnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we === 1'b1) begin
          if (mem_be[0]) mem[mem_addr][7:0]  = mem_wdata[7:0];
          if (mem_be[1]) mem[mem_addr][15:8] = mem_wdata[15:8];
        end
        log_addr.push_back(mem_addr);
        log_we.push_back(mem_we);
        log_be.push_back(mem_be);
        log_wdata.push_back(mem_wdata);
        pending = 1'b0;
        req_idx++;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        wcnt--;
      end
    end else begin
      pending   = 1'b0;
      mem_ack   = stray_ack;
      mem_rdata = 16'hFFFF;
    end
  end

  // Retire pulse monitor.
  always @(negedge clk) begin
    cyc_cnt++;
    if (retire === 1'b1) begin
      ret_cnt++;
      ret_q.push_back(cyc_cnt);
    end
  end

  task automatic set_waits(input int lo, input int hi);
    for (int i = 0; i < 256; i++) wait_seq[i] = $urandom_range(hi, lo);
  endtask

  task automatic fill_mem(input logic [15:0] v);
    for (int i = 0; i < 128; i++) mem[i] = v;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req_idx = 0;
    ret_cnt = 0;
    ret_q.delete();
    log_addr.delete(); log_we.delete(); log_be.delete(); log_wdata.delete();
  endtask

  task automatic release_and_run(input int budget, output int cycles, output bit ok);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    cycles = 0;
    ok     = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cycles++;
    end
  endtask

  // Instruction-level reference: runs from word 0 until HALT.
  task automatic iss(output int n_instr, output int n_req);
    int p, w, op, rd, r1, r2, imm, a, hi;
    p = 0; n_instr = 0; n_req = 0;
    for (int i = 0; i < 16; i++) ref_regs[i] = 0;
    for (int s = 0; s < 500; s++) begin
      w = int'(ref_mem[p]);
      p = (p + 1) % 128;
      n_instr++; n_req++;
      op = w >> 12; rd = (w >> 8) & 15; r1 = (w >> 4) & 15; r2 = w & 15; imm = w & 255;
      if (op == 15) break;
      a  = ref_regs[r1] / 2;
      hi = ref_regs[r1] % 2;
      case (op)
        0: ref_regs[rd] = (ref_regs[r1] + ref_regs[r2]) % 256;
        1: ref_regs[rd] = (ref_regs[r1] - ref_regs[r2] + 256) % 256;
        2: ref_regs[rd] = ref_regs[r1] & ref_regs[r2];
        3: ref_regs[rd] = ref_regs[r1] | ref_regs[r2];
        4: ref_regs[rd] = ref_regs[r1] ^ ref_regs[r2];
        5: ref_regs[rd] = imm;
        6: begin
          n_req++;
          ref_regs[rd] = hi ? (int'(ref_mem[a]) >> 8) : (int'(ref_mem[a]) & 255);
        end
        7: begin
          n_req++;
          if (hi) ref_mem[a] = 16'((int'(ref_mem[a]) & 255) + ref_regs[r2] * 256);
          else    ref_mem[a] = 16'((int'(ref_mem[a]) & 65280) + ref_regs[r2]);
        end
        8: p = imm % 128;
        9: if (ref_regs[rd] == 0) p = imm % 128;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    fill_mem(16'hF000);
    set_waits(0, 0);
    reset_dut();
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || retire !== 1'b0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl: got req=%b we=%b retire=%b halted=%b, required all 0", mem_req, mem_we, retire, halted);
    end
    total++;
    if (pc !== 7'h00) begin bad++; $display("FAIL reset_pc: got %h, required 00", pc); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (dut.regs_r[i] !== 8'h00) begin bad++; $display("FAIL reset_reg R%0d: got %h, required 00", i, dut.regs_r[i]); end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 7'h00 || mem_be !== 2'b11) begin
      bad++;
      $display("FAIL first_fetch: got req=%b we=%b addr=%h be=%b, required 1 0 00 11", mem_req, mem_we, mem_addr, mem_be);
    end
  endtask

  task automatic run_basic(input int waits, input int exp_cycles, input string tag);
    int cycles;
    bit ok;
    fill_mem(16'hA000);
    mem[0] = 16'h510A; mem[1] = 16'h5202; mem[2] = 16'h0312; mem[3] = 16'hF000;
    set_waits(waits, waits);
    reset_dut();
    release_and_run(200, cycles, ok);
    total++;
    if (!ok || cycles != exp_cycles) begin
      bad++; $display("FAIL %s_cycles: got halted=%b after %0d cycles, required halt after %0d", tag, ok, cycles, exp_cycles);
    end
    total++;
    if (ret_cnt != 4) begin bad++; $display("FAIL %s_retires: got %0d, required 4", tag, ret_cnt); end
    total++;
    if (dut.regs_r[1] !== 8'd10 || dut.regs_r[2] !== 8'd2 || dut.regs_r[3] !== 8'd12) begin
      bad++; $display("FAIL %s_regs: got R1=%0d R2=%0d R3=%0d, required 10 2 12", tag, dut.regs_r[1], dut.regs_r[2], dut.regs_r[3]);
    end
    if (ret_q.size() == 4) begin
      total++;
      if (ret_q[2] - ret_q[1] != waits + 2) begin
        bad++; $display("FAIL %s_add_latency: got %0d, required %0d", tag, ret_q[2] - ret_q[1], waits + 2);
      end
    end
  endtask

  task automatic test_basic();
    run_basic(0, 8, "basic");
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    stray_ack = 1'b0;
    total++;
    if (halted !== 1'b1 || ret_cnt != 4 || mem_req !== 1'b0) begin
      bad++; $display("FAIL halt_stray_ack: got halted=%b retires=%0d req=%b, required 1 4 0", halted, ret_cnt, mem_req);
    end
  endtask

  task automatic test_wait();
    run_basic(3, 20, "wait3");
  endtask

  task automatic test_ld_st();
    int cycles, nw, wi;
    bit ok;
    fill_mem(16'h0000);
    mem[0] = 16'h5421; mem[1] = 16'h55AB; mem[2] = 16'h7045; mem[3] = 16'h6640; mem[4] = 16'hF000;
    set_waits(0, 1);
    reset_dut();
    release_and_run(100, cycles, ok);
    nw = 0; wi = 0;
    for (int i = 0; i < log_we.size(); i++) if (log_we[i]) begin nw++; wi = i; end
    total++;
    if (nw != 1) begin
      bad++; $display("FAIL st_count: got %0d writes, required 1", nw);
    end else begin
      total++;
      if (log_addr[wi] !== 7'h10 || log_be[wi] !== 2'b10 || log_wdata[wi] !== 16'hABAB) begin
        bad++; $display("FAIL st_bus: got addr=%h be=%b wdata=%h, required 10 10 abab", log_addr[wi], log_be[wi], log_wdata[wi]);
      end
    end
    total++;
    if (!ok || dut.regs_r[6] !== 8'hAB) begin bad++; $display("FAIL ld_byte: got R6=%h halted=%b, required ab 1", dut.regs_r[6], ok); end
  endtask

  task automatic test_bz();
    int cycles;
    bit ok;
    for (int t = 0; t < 2; t++) begin
      fill_mem(16'hF000);
      mem[0] = (t == 0) ? 16'h5100 : 16'h5101;
      mem[1] = 16'h9120;
      set_waits(0, 2);
      reset_dut();
      release_and_run(100, cycles, ok);
      total++;
      if (log_addr.size() < 3 || log_addr[2] !== ((t == 0) ? 7'h20 : 7'h02)) begin
        bad++; $display("FAIL bz_target_%0d: got %0d fetches, third at %h, required %h", t, log_addr.size(),
                        (log_addr.size() >= 3) ? log_addr[2] : 7'h00, (t == 0) ? 7'h20 : 7'h02);
      end
    end
  endtask

  task automatic test_wrap();
    fill_mem(16'hF000);
    mem[0] = 16'h807F; mem[127] = 16'hA000;
    set_waits(0, 0);
    reset_dut();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    total++;
    if (log_addr.size() < 3 || log_addr[0] !== 7'h00 || log_addr[1] !== 7'h7F || log_addr[2] !== 7'h00) begin
      bad++; $display("FAIL pc_wrap: got %0d fetches, required sequence 00 7f 00", log_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    fill_mem(16'hF000);
    mem[0] = 16'h6600;
    set_waits(0, 0);
    wait_seq[1] = 20;
    reset_dut();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL ld_pending: got req=%b we=%b, required 1 0", mem_req, mem_we); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (mem_req !== 1'b0 || retire !== 1'b0) begin bad++; $display("FAIL req_in_reset: got req=%b retire=%b, required 0 0", mem_req, retire); end
    stray_ack = 1'b0;
    @(negedge clk);
    total++;
    if (dut.regs_r[6] !== 8'h00 || pc !== 7'h00 || ret_cnt != 0) begin
      bad++; $display("FAIL abandon_ld: got R6=%h pc=%h retires=%0d, required 00 00 0", dut.regs_r[6], pc, ret_cnt);
    end
    req_idx = 0;
    log_addr.delete(); log_we.delete(); log_be.delete(); log_wdata.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (log_addr.size() < 1 || log_addr[0] !== 7'h00) begin bad++; $display("FAIL refetch_addr: got %0d fetches, required first at 00", log_addr.size()); end
  endtask

  task automatic test_random();
    int cycles, n_instr, n_req, exp_cyc;
    bit ok;
    logic [3:0] op, rd, ra, rb;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
      mem[0] = {4'h5, 4'hE, 8'($urandom_range(255, 64))};
      mem[1] = {4'h5, 4'hF, 8'($urandom_range(255, 64))};
      for (int k = 2; k < 22; k++) begin
        rd = 4'($urandom_range(13, 0));
        ra = 4'($urandom_range(15, 0));
        rb = 4'($urandom_range(15, 0));
        case ($urandom_range(5, 0))
          0, 1:    op = 4'($urandom_range(4, 0));
          2:       op = 4'h5;
          3:       begin op = 4'h6; ra = 4'($urandom_range(15, 14)); end
          4:       begin op = 4'h7; ra = 4'($urandom_range(15, 14)); end
          default: op = 4'($urandom_range(14, 10));
        endcase
        mem[k] = {op, rd, ra, rb};
      end
      mem[22] = 16'hF000;
      for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];
      set_waits(0, 2);
      iss(n_instr, n_req);
      exp_cyc = n_instr;
      for (int k = 0; k < n_req; k++) exp_cyc += wait_seq[k] + 1;
      reset_dut();
      release_and_run(500, cycles, ok);
      total++;
      if (!ok || cycles != exp_cyc) begin bad++; $display("FAIL rnd%0d_cycles: got halted=%b after %0d, required %0d", it, ok, cycles, exp_cyc); end
      total++;
      if (ret_cnt != n_instr) begin bad++; $display("FAIL rnd%0d_retires: got %0d, required %0d", it, ret_cnt, n_instr); end
      for (int i = 0; i < 16; i++) begin
        total++;
        if (dut.regs_r[i] !== 8'(ref_regs[i])) begin
          bad++; $display("FAIL rnd%0d_reg R%0d: got %h, required %h", it, i, dut.regs_r[i], 8'(ref_regs[i]));
        end
      end
      for (int i = 0; i < 128; i++) begin
        if (mem[i] !== ref_mem[i]) begin
          total++; bad++;
          $display("FAIL rnd%0d_mem[%0d]: got %h, required %h", it, i, mem[i], ref_mem[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_ld_st();
    test_bz();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
